card: RTL and testbench
=======================

# card

Per-tile state holder for the matching-game board. One instance sits behind every tile. It tracks whether the cursor is on the tile, whether the player has selected it, and whether it has been cleared by a successful match. It drives the tile's highlight, selection and hidden flags to the renderer, plus a one-hot debug view of its state.

## Interface
Parameters:
- BLINK_HALF, default 4: clock cycles per blink half-period while the cursor is on the tile; legal range is 1 or more.

Ports:
- clk, input, 1: single system clock, rising-edge.
- rst, input, 1: reset, asynchronous and active-low (0 = reset).
- cur, input, 1: level, cursor is currently on this tile.
- s, input, 1: select button; acts only on its rising edge.
- mf, input, 1: level, match-fail verdict from the board controller.
- ms, input, 1: level, match-success verdict from the board controller.
- sel, output, 1: tile is selected.
- blink, output, 1: cursor highlight, a square wave while the cursor is on a live tile.
- hidden, output, 1: tile has been cleared.
- state_debug, output, 5: one-hot copy of the current state.

## Operation
- States, with their one-hot state_debug codes:
  - IDLE = 00001
  - HOVER = 00010
  - SELECTED = 00100
  - SEL_HOVER = 01000
  - GONE = 10000
- Select edge: s_rise = s & ~s_q, where s_q is s registered each clock. s_q resets to 0.
- Transition priority within one cycle is ms > mf > s_rise > cur.
- IDLE:
  - cur=1 -> HOVER.
  - ms, mf and s_rise are ignored.
- HOVER:
  - s_rise -> SELECTED if cur=0, otherwise SEL_HOVER.
  - Else cur=0 -> IDLE.
  - ms and mf are ignored.
- SELECTED (cursor off the tile):
  - ms -> GONE.
  - Else mf -> IDLE.
  - Else cur=1 -> SEL_HOVER.
- SEL_HOVER:
  - ms -> GONE.
  - Else mf -> HOVER if cur=1, otherwise IDLE.
  - Else s_rise -> HOVER (deselect) if cur=1, otherwise IDLE.
  - Else cur=0 -> SELECTED.
- GONE: absorbing. Only reset leaves it; all inputs are ignored.
- Output decode (Moore, derived from the state register only):
  - sel = SELECTED | SEL_HOVER.
  - hidden = GONE.
  - blink = (HOVER | SEL_HOVER) & phase.
- Blink generator:
  - Counter runs 0..BLINK_HALF-1; phase is a toggle flop.
  - When the next state is not HOVER or SEL_HOVER, the counter goes to 0 and phase goes to 1.
  - In HOVER or SEL_HOVER, when the counter reaches BLINK_HALF-1 it wraps to 0 and phase toggles.
  - Moving between HOVER and SEL_HOVER does not restart the blink pattern.
  - Counter width is clog2(BLINK_HALF), minimum 1.

## Timing
- Reset (rst=0, asynchronous):
  - State goes to IDLE; state_debug = 00001.
  - sel=0, blink=0, hidden=0, s_q=0, counter=0, phase=1.
- Release of rst is treated as synchronous to clk by the surrounding design.
- Inputs are sampled on the rising edge of clk. The state changes at that edge, and outputs follow within the same cycle, combinationally from the state.
- Latency is one edge from input to state.
- s_rise needs s=0 at one edge and s=1 at the next.
  - A held s produces exactly one action.
  - A 1-cycle pulse is sufficient.
- s asserted in the same cycle as rst is released does not count as an edge unless s was sampled low first.
- ms and mf are levels; holding them is harmless.
  - In IDLE and HOVER they are ignored.
  - A held ms produces one transition to GONE, after which GONE ignores it.
- Entering HOVER or SEL_HOVER: blink=1 for the first BLINK_HALF cycles, then 0 for BLINK_HALF cycles, and so on.
- Reset mid-blink or while in GONE restores every reset value immediately.

## Test plan
- Reset and hover: hold rst=0 -> state_debug=00001, all outputs 0. Release, set cur=1 -> next edge HOVER (00010), blink=1 for 4 cycles then 0 for 4. cur=0 -> IDLE, blink=0.
- Verdicts without selection: in IDLE assert s=1 and ms=1 for 5 cycles -> state stays 00001, hidden=0, sel=0.
- Select and move: cur=1, 1-cycle s pulse -> SEL_HOVER (01000), sel=1. cur=0 -> SELECTED (00100), sel=1, blink=0. cur=1 -> SEL_HOVER.
- Deselect and held select: in SEL_HOVER pulse s -> HOVER, sel=0. Then hold s=1 for 5 cycles -> exactly one select (SEL_HOVER) with no toggling back. A later ms in HOVER has no effect.
- Match fail: in SELECTED assert mf -> IDLE, sel=0. In SEL_HOVER assert mf -> HOVER.
- Match success and priority: in SELECTED assert ms and mf together -> GONE (10000), hidden=1, sel=0. Then cur=1 with s pulses -> blink=0 and the state stays GONE until rst=0.

Source files
------------

// File: rtl/card.sv
`default_nettype none
// ============================================================================
// Module      : card
// Description : Per-tile state holder for the matching-game board. Tracks
//               cursor presence, player selection and cleared status, and
//               drives the tile's highlight, selection and hidden flags.
// Ports       : clk         - system clock, rising edge
//               rst         - asynchronous reset, active low
//               cur         - cursor is on this tile (level)
//               s           - select button (acts on rising edge only)
//               mf / ms     - match-fail / match-success verdicts (levels)
//               sel         - tile is selected
//               blink       - cursor highlight square wave
//               hidden      - tile has been cleared
//               state_debug - one-hot copy of the current state
// Revision    : 1.0 - initial release
// ============================================================================
module card #(
    parameter int BLINK_HALF = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cur,
    input  logic       s,
    input  logic       mf,
    input  logic       ms,
    output logic       sel,
    output logic       blink,
    output logic       hidden,
    output logic [4:0] state_debug
);

    localparam int c_CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(BLINK_HALF - 1);

    typedef enum logic [4:0] {
        ST_IDLE      = 5'b00001,
        ST_HOVER     = 5'b00010,
        ST_SELECTED  = 5'b00100,
        ST_SEL_HOVER = 5'b01000,
        ST_GONE      = 5'b10000
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_s_q;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_phase;
    logic                 w_s_rise;
    logic                 w_hover_now;
    logic                 w_hover_next;

    assign w_s_rise     = s & ~r_s_q;
    assign w_hover_now  = (r_state == ST_HOVER) || (r_state == ST_SEL_HOVER);
    assign w_hover_next = (w_next  == ST_HOVER) || (w_next  == ST_SEL_HOVER);

    // Next-state decode; priority within a cycle is ms > mf > s_rise > cur.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cur) w_next = ST_HOVER;
            end
            ST_HOVER: begin
                if (w_s_rise)  w_next = cur ? ST_SEL_HOVER : ST_SELECTED;
                else if (!cur) w_next = ST_IDLE;
            end
            ST_SELECTED: begin
                if (ms)       w_next = ST_GONE;
                else if (mf)  w_next = ST_IDLE;
                else if (cur) w_next = ST_SEL_HOVER;
            end
            ST_SEL_HOVER: begin
                if (ms)            w_next = ST_GONE;
                else if (mf)       w_next = cur ? ST_HOVER : ST_IDLE;
                else if (w_s_rise) w_next = cur ? ST_HOVER : ST_IDLE;
                else if (!cur)     w_next = ST_SELECTED;
            end
            ST_GONE: begin
                w_next = ST_GONE;
            end
            default: begin
                // Any non-one-hot value recovers to a safe state.
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_s_q   <= 1'b0;
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else begin
            r_state <= w_next;
            r_s_q   <= s;
            if (!w_hover_next) begin
                r_cnt   <= '0;
                r_phase <= 1'b1;
            end else if (w_hover_now) begin
                // Count only while already hovering, so the first highlighted
                // half-period after entry is a full BLINK_HALF cycles long.
                // HOVER <-> SEL_HOVER moves keep counting without restart.
                if (r_cnt == c_CNT_MAX) begin
                    r_cnt   <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_cnt   <= r_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    // Moore outputs, decoded from the state register only.
    assign state_debug = r_state;
    assign sel         = (r_state == ST_SELECTED) || (r_state == ST_SEL_HOVER);
    assign hidden      = (r_state == ST_GONE);
    assign blink       = w_hover_now & r_phase;

endmodule
`default_nettype wire

// File: tb/tb_card.sv
`default_nettype none
// ============================================================================
// Module      : tb_card
// Description : Self-checking bench for card. A table of input vectors with
//               expected post-edge outputs is applied in a loop; expected
//               records go through a scoreboard queue. Hand-written sequences
//               cover asynchronous reset and select-held-through-reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_card;

    localparam logic [4:0] I  = 5'b00001;
    localparam logic [4:0] H  = 5'b00010;
    localparam logic [4:0] S  = 5'b00100;
    localparam logic [4:0] SH = 5'b01000;
    localparam logic [4:0] G  = 5'b10000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cur = 1'b0;
    logic       s   = 1'b0;
    logic       mf  = 1'b0;
    logic       ms  = 1'b0;
    logic       sel;
    logic       blink;
    logic       hidden;
    logic [4:0] state_debug;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       cur, s, mf, ms;
        logic [4:0] st;
        logic       sel, blink, hidden;
    } vec_t;

    typedef struct {
        int         idx;
        logic [4:0] st;
        logic       sel, blink, hidden;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    card #(.BLINK_HALF(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cur         (cur),
        .s           (s),
        .mf          (mf),
        .ms          (ms),
        .sel         (sel),
        .blink       (blink),
        .hidden      (hidden),
        .state_debug (state_debug)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int idx, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step=%0d actual=%b required=%b", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic c, input logic sv, input logic f, input logic m,
                       input logic [4:0] st, input logic se, input logic b, input logic h);
        vec_t v;
        v.cur = c; v.s = sv; v.mf = f; v.ms = m;
        v.st = st; v.sel = se; v.blink = b; v.hidden = h;
        tbl.push_back(v);
    endtask

    // Drive one vector, push its expectation, clock once, pop and compare.
    task automatic step(input int idx, input vec_t v);
        exp_t e;
        exp_t got;
        cur = v.cur; s = v.s; mf = v.mf; ms = v.ms;
        e.idx = idx; e.st = v.st; e.sel = v.sel; e.blink = v.blink; e.hidden = v.hidden;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("state", got.idx, state_debug, got.st);
        chk("sel",    got.idx, {4'b0, sel},    {4'b0, got.sel});
        chk("blink",  got.idx, {4'b0, blink},  {4'b0, got.blink});
        chk("hidden", got.idx, {4'b0, hidden}, {4'b0, got.hidden});
    endtask

    task automatic check_reset_vals(input int idx);
        chk("rst_state",  idx, state_debug,     I);
        chk("rst_sel",    idx, {4'b0, sel},    5'd0);
        chk("rst_blink",  idx, {4'b0, blink},  5'd0);
        chk("rst_hidden", idx, {4'b0, hidden}, 5'd0);
    endtask

    initial begin
        vec_t v;
        // ---- table: cur, s, mf, ms -> state, sel, blink, hidden ----
        // Hover and blink: 4 high, 4 low, high again, then leave.
        for (int k = 0; k < 4; k++) add(1,0,0,0, H,0,1,0);
        for (int k = 0; k < 4; k++) add(1,0,0,0, H,0,0,0);
        add(1,0,0,0, H,0,1,0);
        add(0,0,0,0, I,0,0,0);
        // Verdicts and select ignored in IDLE.
        for (int k = 0; k < 5; k++) add(0,1,0,1, I,0,0,0);
        add(0,0,0,0, I,0,0,0);
        // Select and move; blink continues across HOVER -> SEL_HOVER.
        add(1,0,0,0, H,0,1,0);
        add(1,1,0,0, SH,1,1,0);
        add(1,0,0,0, SH,1,1,0);
        add(0,0,0,0, S,1,0,0);
        add(1,0,0,0, SH,1,1,0);
        // Deselect, then held select gives exactly one action.
        add(1,1,0,0, H,0,1,0);
        add(1,0,0,0, H,0,1,0);
        add(1,1,0,0, SH,1,1,0);
        add(1,1,0,0, SH,1,0,0);
        for (int k = 0; k < 3; k++) add(1,1,0,0, SH,1,0,0);
        add(1,0,0,0, SH,1,1,0);
        // Deselect; ms in HOVER ignored.
        add(1,1,0,0, H,0,1,0);
        add(1,0,0,1, H,0,1,0);
        add(1,0,0,1, H,0,1,0);
        add(1,0,0,0, H,0,0,0);
        // Match fail from SELECTED and SEL_HOVER.
        add(1,1,0,0, SH,1,0,0);
        add(0,0,0,0, S,1,0,0);
        add(0,0,1,0, I,0,0,0);
        add(1,0,0,0, H,0,1,0);
        add(1,1,0,0, SH,1,1,0);
        add(1,0,1,0, H,0,1,0);
        add(0,0,0,0, I,0,0,0);
        add(1,0,0,0, H,0,1,0);
        add(1,1,0,0, SH,1,1,0);
        add(0,0,1,0, I,0,0,0);
        // Match success with ms+mf together; GONE absorbs everything.
        add(1,0,0,0, H,0,1,0);
        add(1,1,0,0, SH,1,1,0);
        add(0,0,0,0, S,1,0,0);
        add(0,0,1,1, G,0,0,1);
        add(1,1,0,0, G,0,0,1);
        add(1,0,0,0, G,0,0,1);
        add(1,1,1,0, G,0,0,1);
        add(1,0,0,1, G,0,0,1);

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals(-1);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(i, tbl[i]);

        // ---- asynchronous reset while GONE, no clock edge needed ----
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals(100);

        // ---- s held high through reset release: no select action ----
        cur = 1'b1; s = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        v.cur = 1; v.s = 1; v.mf = 0; v.ms = 0; v.sel = 0; v.hidden = 0;
        v.st = H; v.blink = 1; step(200, v);
        v.st = H; v.blink = 1; step(201, v);
        v.st = H; v.blink = 1; step(202, v);

        // ---- asynchronous reset mid-blink, then blink pattern restarts ----
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals(300);
        @(negedge clk);
        rst = 1'b1;
        v.s = 0;
        for (int k = 0; k < 4; k++) begin
            v.st = H; v.blink = 1; step(400 + k, v);
        end
        v.st = H; v.blink = 0; step(404, v);

        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
